// File: rtl/alu_isa_pkg.sv
// Shared ISA definitions for the ALU instruction issuer and decoder.
// Holds the OPR field constants, the host op codes, the issuer state
// encoding, and the command validation and encoding helpers.
package alu_isa_pkg;

  // OPR field values; the decoder uses the same constants.
  localparam logic [3:0] OPR_NOP   = 4'h0;
  localparam logic [3:0] OPR_LOAD  = 4'h1;
  localparam logic [3:0] OPR_MODE1 = 4'h2;
  localparam logic [3:0] OPR_MODE2 = 4'h3;
  localparam logic [3:0] OPR_MODE3 = 4'h4;
  localparam logic [3:0] OPR_MODE4 = 4'h5;

  // Host command op codes; 5..7 are illegal.
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_MODE1 = 3'd1;
  localparam logic [2:0] OP_MODE2 = 3'd2;
  localparam logic [2:0] OP_MODE3 = 3'd3;
  localparam logic [2:0] OP_MODE4 = 3'd4;

  // Highest register index a MODE command may name.
  localparam logic [3:0] MAX_INDEX = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2
  } issuer_state_e;

  typedef struct packed {
    logic [3:0] opr;
    logic [3:0] opa;
  } instr_t;

  // LOAD takes any 4-bit immediate; MODE needs a register index 0..7.
  function automatic logic cmd_legal(input logic [2:0] op, input logic [3:0] arg);
    logic ok;
    ok = 1'b0;
    if (op == OP_LOAD)
      ok = 1'b1;
    else if (op <= OP_MODE4)
      ok = (arg <= MAX_INDEX);
    return ok;
  endfunction

  // MODEk maps to OPR k+1, which lands MODE1..4 on OPR_MODE1..4.
  function automatic instr_t encode(input logic [2:0] op, input logic [3:0] arg);
    instr_t w;
    w.opa = arg;
    if (op == OP_LOAD)
      w.opr = OPR_LOAD;
    else
      w.opr = {1'b0, op} + 4'd1;
    return w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding pre-encoded instruction words.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (flushes contents)
//   push_i, wdata_i   write strobe and word; ignored while full
//   pop_i, rdata_o    read strobe and head word (show-ahead); ignored while empty
//   full_o, empty_o   occupancy flags derived from the registered pointers
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_instruction_issuer.sv
// Command-side initiator for the ALU instruction decoder. Host commands are
// validated and encoded at accept time, queued, then issued one at a time on
// the instruction bus. Each word is held until the decoder toggles
// processing (or a timeout), followed by one cycle of NOP so repeated
// identical words still appear as changes.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o host handshake; ready = FIFO not full
//   cmd_op_i, cmd_arg_i     command op (0 LOAD, 1..4 MODE) and argument
//   instruction_o           registered {OPR, OPA} word to the decoder
//   processing_i            decoder acknowledge, any toggle = consumed
//   busy_o                  FSM active or commands queued
//   err_reject_o            pulse after an illegal command was accepted
//   err_timeout_o           pulse when an instruction was abandoned
//   issued_count_o          acknowledged instruction count, wraps
module alu_instruction_issuer
  import alu_isa_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_op_i,
  input  logic [3:0] cmd_arg_i,
  output logic [7:0] instruction_o,
  input  logic       processing_i,
  output logic       busy_o,
  output logic       err_reject_o,
  output logic       err_timeout_o,
  output logic [7:0] issued_count_o
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  issuer_state_e state_q, state_d;
  logic [7:0]    instr_q, instr_d;
  logic          ref_q, ref_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]    issued_q, issued_d;
  logic          err_to_q, err_to_d;
  logic          err_rej_q, err_rej_d;

  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [7:0]    fifo_rdata;
  logic          accept, legal;
  instr_t        enc_word;

  // Validation and encoding happen once, at accept; the FIFO stores words.
  assign accept    = cmd_valid_i & cmd_ready_o;
  assign legal     = cmd_legal(cmd_op_i, cmd_arg_i);
  assign enc_word  = encode(cmd_op_i, cmd_arg_i);
  assign fifo_push = accept & legal;
  assign err_rej_d = accept & ~legal;

  cmd_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (enc_word),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ref_d      = ref_q;
    wait_cnt_d = wait_cnt_q;
    issued_d   = issued_q;
    err_to_d   = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      // GAP and IDLE share the issue path: GAP only guarantees one NOP cycle.
      ST_IDLE, ST_GAP: begin
        instr_d = {OPR_NOP, 4'h0};
        state_d = ST_IDLE;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          instr_d    = fifo_rdata;
          // Re-capturing here makes toggles seen outside WAIT_ACK harmless.
          ref_d      = processing_i;
          wait_cnt_d = '0;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Acknowledge is checked first so it wins over a same-edge timeout.
        if (processing_i != ref_q) begin
          instr_d  = {OPR_NOP, 4'h0};
          issued_d = issued_q + 8'd1;
          state_d  = ST_GAP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          instr_d  = {OPR_NOP, 4'h0};
          err_to_d = 1'b1;
          state_d  = ST_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        instr_d = {OPR_NOP, 4'h0};
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      ref_q      <= 1'b0;
      wait_cnt_q <= '0;
      issued_q   <= '0;
      err_to_q   <= 1'b0;
      err_rej_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ref_q      <= ref_d;
      wait_cnt_q <= wait_cnt_d;
      issued_q   <= issued_d;
      err_to_q   <= err_to_d;
      err_rej_q  <= err_rej_d;
    end
  end

  assign cmd_ready_o    = ~fifo_full;
  assign instruction_o  = instr_q;
  assign busy_o         = (state_q != ST_IDLE) | ~fifo_empty;
  assign err_reject_o   = err_rej_q;
  assign err_timeout_o  = err_to_q;
  assign issued_count_o = issued_q;

endmodule

// File: tb/tb_alu_instruction_issuer.sv
// Directed bench for alu_instruction_issuer: a table of single-command
// vectors plus hand-written multi-cycle sequences (full FIFO, timeout,
// identical words, reset mid-operation).
module tb_alu_instruction_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [7:0] instruction;
  logic       processing;
  logic       busy;
  logic       err_reject;
  logic       err_timeout;
  logic [7:0] issued_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_instruction_issuer #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_op_i       (cmd_op),
    .cmd_arg_i      (cmd_arg),
    .instruction_o  (instruction),
    .processing_i   (processing),
    .busy_o         (busy),
    .err_reject_o   (err_reject),
    .err_timeout_o  (err_timeout),
    .issued_count_o (issued_count)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] arg;
    logic       rej;
    logic [7:0] word;
    string      name;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [3:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq_full [10];
    logic [7:0] exp_full [10];
    logic [7:0] seq_same [4];
    logic [7:0] exp_same [4];
    int got;

    exp_full = '{8'h12, 8'h00, 8'h23, 8'h00, 8'h34, 8'h00, 8'h45, 8'h00, 8'h56, 8'h00};
    exp_same = '{8'h27, 8'h00, 8'h27, 8'h00};

    vecs[0] = '{3'd0, 4'hA, 1'b0, 8'h1A, "load_a"};
    vecs[1] = '{3'd1, 4'h7, 1'b0, 8'h27, "mode1_7"};
    vecs[2] = '{3'd3, 4'h5, 1'b0, 8'h45, "mode3_5"};
    vecs[3] = '{3'd4, 4'h0, 1'b0, 8'h50, "mode4_0"};
    vecs[4] = '{3'd0, 4'hF, 1'b0, 8'h1F, "load_f"};
    vecs[5] = '{3'd2, 4'h9, 1'b1, 8'h00, "mode2_9_rej"};
    vecs[6] = '{3'd1, 4'h8, 1'b1, 8'h00, "mode1_8_rej"};
    vecs[7] = '{3'd6, 4'h1, 1'b1, 8'h00, "op6_rej"};
    vecs[8] = '{3'd5, 4'h0, 1'b1, 8'h00, "op5_rej"};
    vecs[9] = '{3'd7, 4'h3, 1'b1, 8'h00, "op7_rej"};

    processing = 1'b0;
    cmd_op = '0;
    cmd_arg = '0;
    do_reset();

    check("rst_instruction", instruction, 8'h00);
    check("rst_count", issued_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_err_reject", err_reject, 0);
    check("rst_err_timeout", err_timeout, 0);

    // Single-command vectors, each starting and ending in IDLE.
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].op, vecs[i].arg);
      check($sformatf("%s_reject", vecs[i].name), err_reject, vecs[i].rej);
      check($sformatf("%s_busy", vecs[i].name), busy, !vecs[i].rej);
      step();
      check($sformatf("%s_reject_width", vecs[i].name), err_reject, 0);
      if (!vecs[i].rej) begin
        check($sformatf("%s_word", vecs[i].name), instruction, vecs[i].word);
        processing = ~processing;
        step();
        exp_cnt++;
        check($sformatf("%s_ack_nop", vecs[i].name), instruction, 8'h00);
        check($sformatf("%s_count", vecs[i].name), issued_count, exp_cnt);
        step();
        check($sformatf("%s_idle", vecs[i].name), busy, 0);
      end else begin
        check($sformatf("%s_no_issue", vecs[i].name), instruction, 8'h00);
        check($sformatf("%s_count", vecs[i].name), issued_count, exp_cnt);
      end
    end

    // LOAD with acknowledge two cycles after the word appears.
    push(3'd0, 4'hA);
    check("load_latency_e0", instruction, 8'h00);
    step();
    check("load_latency_e1", instruction, 8'h1A);
    step();
    step();
    check("load_hold", instruction, 8'h1A);
    processing = ~processing;
    step();
    exp_cnt++;
    check("load_ack_nop", instruction, 8'h00);
    check("load_ack_count", issued_count, exp_cnt);
    check("load_gap_busy", busy, 1);
    step();
    check("load_after_gap_busy", busy, 0);

    // Fill the FIFO behind one in-flight word, then drain with a responder.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_ready_%0d", i), cmd_ready, 1);
      push(3'(i), 4'(i + 2));
    end
    check("full_ready_low", cmd_ready, 0);
    check("full_word0", instruction, 8'h12);
    for (int i = 0; i < 10; i++) begin
      seq_full[i] = instruction;
      if (instruction != 8'h00) processing = ~processing;
      step();
    end
    exp_cnt += 5;
    for (int i = 0; i < 10; i++)
      check($sformatf("full_seq_%0d", i), seq_full[i], exp_full[i]);
    check("full_count", issued_count, exp_cnt);
    check("full_drained_busy", busy, 0);
    check("full_ready_back", cmd_ready, 1);

    // Timeout: no toggle, next queued command goes out after the GAP.
    push(3'd0, 4'h3);
    push(3'd1, 4'h1);
    check("to_word", instruction, 8'h13);
    got = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (err_timeout) begin
        got = n;
        break;
      end
    end
    check("to_cycles", got, 15);
    check("to_nop", instruction, 8'h00);
    check("to_count_same", issued_count, exp_cnt);
    step();
    check("to_pulse_width", err_timeout, 0);
    check("to_next_word", instruction, 8'h21);
    processing = ~processing;
    step();
    exp_cnt++;
    check("to_next_ack", issued_count, exp_cnt);
    step();
    check("to_idle", busy, 0);

    // Identical consecutive commands are separated by a NOP.
    push(3'd1, 4'h7);
    push(3'd1, 4'h7);
    for (int i = 0; i < 4; i++) begin
      seq_same[i] = instruction;
      if (instruction != 8'h00) processing = ~processing;
      step();
    end
    exp_cnt += 2;
    for (int i = 0; i < 4; i++)
      check($sformatf("same_seq_%0d", i), seq_same[i], exp_same[i]);
    check("same_count", issued_count, exp_cnt);

    // Reset while waiting for an acknowledge with two commands queued.
    push(3'd0, 4'h1);
    push(3'd0, 4'h2);
    push(3'd0, 4'h3);
    check("mid_busy_before", busy, 1);
    check("mid_word_before", instruction, 8'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    check("mid_rst_instruction", instruction, 8'h00);
    check("mid_rst_count", issued_count, exp_cnt);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout", err_timeout, 0);
    processing = ~processing;
    step();
    step();
    check("mid_stale_count", issued_count, exp_cnt);
    check("mid_stale_instruction", instruction, 8'h00);
    check("mid_stale_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
